// File: rtl/burst_arbiter_pkg.sv
// Shared types for the burst arbiter and the box_master burst senders.
package burst_arbiter_pkg;

   localparam int unsigned ARB_NUM_REQ = 2;

   localparam int unsigned AW_ID_W   = 4;
   localparam int unsigned AW_ADDR_W = 32;
   localparam int unsigned AW_LEN_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [AW_ID_W-1:0]   id;
      logic [AW_ADDR_W-1:0] addr;
      logic [AW_LEN_W-1:0]  len;
      logic [2:0]           size;
      logic [1:0]           burst;
      logic [1:0]           user;
   } aw_fields_t;

   // Index following idx, wrapping modulo n.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/burst_arbiter_rr_pick.sv
// Combinational masked round-robin selector: first requester at or after
// ptr, wrapping, returned as one-hot grant plus its index.
module burst_arbiter_rr_pick #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [PTR_W-1:0]   gnt_idx
);

   logic [NUM_REQ-1:0] hi;
   logic [NUM_REQ-1:0] src;

   // Prefer requesters at/after the pointer; fall back to the full set (wrap).
   always_comb begin
      hi = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         hi[j] = req[j] && (PTR_W'(j) >= ptr);
      end
      src     = (|hi) ? hi : req;
      gnt     = '0;
      gnt_idx = '0;
      // Descending scan so the lowest set index wins.
      for (int unsigned j = NUM_REQ; j > 0; j--) begin
         if (src[j-1]) begin
            gnt      = '0;
            gnt[j-1] = 1'b1;
            gnt_idx  = PTR_W'(j-1);
         end
      end
   end

endmodule

// File: rtl/burst_arbiter.sv
// Whole-burst AXI write arbiter: NUM_REQ burst sources share one AW/W port.
// Urgent requesters take precedence, otherwise round-robin.
// Optional build macro BURST_ARB_LEN_CHECK_EN adds the len_err output that
// flags wlast arriving on the wrong beat relative to awlen.
module burst_arbiter
   import burst_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = ARB_NUM_REQ,
   parameter int unsigned ID_W    = 4,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LEN_W   = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          r_awvalid,
   output logic [NUM_REQ-1:0]          r_awready,
   input  logic [NUM_REQ*ID_W-1:0]     r_awid,
   input  logic [NUM_REQ*ADDR_W-1:0]   r_awaddr,
   input  logic [NUM_REQ*LEN_W-1:0]    r_awlen,
   input  logic [NUM_REQ*3-1:0]        r_awsize,
   input  logic [NUM_REQ*2-1:0]        r_awburst,
   input  logic [NUM_REQ*2-1:0]        r_awuser,
   input  logic [NUM_REQ-1:0]          r_urgent,
   input  logic [NUM_REQ-1:0]          r_wvalid,
   output logic [NUM_REQ-1:0]          r_wready,
   input  logic [NUM_REQ*DATA_W-1:0]   r_wdata,
   input  logic [NUM_REQ*DATA_W/8-1:0] r_wstrb,
   input  logic [NUM_REQ-1:0]          r_wlast,
   output logic                        m_awvalid,
   input  logic                        m_awready,
   output logic [ID_W-1:0]             m_awid,
   output logic [ADDR_W-1:0]           m_awaddr,
   output logic [LEN_W-1:0]            m_awlen,
   output logic [2:0]                  m_awsize,
   output logic [1:0]                  m_awburst,
   output logic [1:0]                  m_awuser,
   output logic                        m_wvalid,
   input  logic                        m_wready,
   output logic [DATA_W-1:0]           m_wdata,
   output logic [DATA_W/8-1:0]         m_wstrb,
   output logic                        m_wlast,
   output logic [NUM_REQ-1:0]          grant,
   output logic                        busy
`ifdef BURST_ARB_LEN_CHECK_EN
   ,
   output logic                        len_err
`endif
);

   localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned STRB_W = DATA_W / 8;

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]   gidx_q, gidx_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
`ifdef BURST_ARB_LEN_CHECK_EN
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W:0]     beat_q, beat_d;
   logic               len_err_q, len_err_d;
`endif

   logic [NUM_REQ-1:0] urg_req;
   logic [NUM_REQ-1:0] pick_req;
   logic [NUM_REQ-1:0] win_gnt;
   logic [PTR_W-1:0]   win_idx;

   // Urgent requesters, when present, are the only candidates.
   always_comb begin
      urg_req  = r_awvalid & r_urgent;
      pick_req = (|urg_req) ? urg_req : r_awvalid;
   end

   burst_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .req     (pick_req),
      .ptr     (rr_ptr_q),
      .gnt     (win_gnt),
      .gnt_idx (win_idx)
   );

   // State register and arbitration bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         gidx_q    <= '0;
         rr_ptr_q  <= '0;
`ifdef BURST_ARB_LEN_CHECK_EN
         len_q     <= '0;
         beat_q    <= '0;
         len_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         gidx_q    <= gidx_d;
         rr_ptr_q  <= rr_ptr_d;
`ifdef BURST_ARB_LEN_CHECK_EN
         len_q     <= len_d;
         beat_q    <= beat_d;
         len_err_q <= len_err_d;
`endif
      end
   end

   // Next state and channel muxing; payloads are zero outside their phase.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gidx_d    = gidx_q;
      rr_ptr_d  = rr_ptr_q;
`ifdef BURST_ARB_LEN_CHECK_EN
      len_d     = len_q;
      beat_d    = beat_q;
      len_err_d = 1'b0;
`endif
      r_awready = '0;
      r_wready  = '0;
      m_awvalid = 1'b0;
      m_awid    = '0;
      m_awaddr  = '0;
      m_awlen   = '0;
      m_awsize  = '0;
      m_awburst = '0;
      m_awuser  = '0;
      m_wvalid  = 1'b0;
      m_wdata   = '0;
      m_wstrb   = '0;
      m_wlast   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (|r_awvalid) begin
               grant_d = win_gnt;
               gidx_d  = win_idx;
               state_d = ADDR;
            end
         end
         ADDR: begin
            // Follows the owner's awvalid even if it drops; no regrant.
            m_awvalid = |(r_awvalid & grant_q);
            r_awready = grant_q & {NUM_REQ{m_awready}};
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
               if (grant_q[k]) begin
                  m_awid    = r_awid[k*ID_W +: ID_W];
                  m_awaddr  = r_awaddr[k*ADDR_W +: ADDR_W];
                  m_awlen   = r_awlen[k*LEN_W +: LEN_W];
                  m_awsize  = r_awsize[k*3 +: 3];
                  m_awburst = r_awburst[k*2 +: 2];
                  m_awuser  = r_awuser[k*2 +: 2];
               end
            end
            if (m_awvalid && m_awready) begin
               state_d = DATA;
`ifdef BURST_ARB_LEN_CHECK_EN
               len_d   = m_awlen;
               beat_d  = '0;
`endif
            end
         end
         DATA: begin
            m_wvalid = |(r_wvalid & grant_q);
            r_wready = grant_q & {NUM_REQ{m_wready}};
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
               if (grant_q[k]) begin
                  m_wdata = r_wdata[k*DATA_W +: DATA_W];
                  m_wstrb = r_wstrb[k*STRB_W +: STRB_W];
                  m_wlast = r_wlast[k];
               end
            end
            if (m_wvalid && m_wready) begin
`ifdef BURST_ARB_LEN_CHECK_EN
               beat_d    = (&beat_q) ? beat_q : beat_q + 1'b1;
               len_err_d = m_wlast ? (beat_q != {1'b0, len_q})
                                   : (beat_q == {1'b0, len_q});
`endif
               if (m_wlast) begin
                  state_d  = IDLE;
                  grant_d  = '0;
                  rr_ptr_d = PTR_W'(rr_next(32'(gidx_q), NUM_REQ));
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   assign grant = grant_q;
   assign busy  = (state_q != IDLE);
`ifdef BURST_ARB_LEN_CHECK_EN
   assign len_err = len_err_q;
`endif

endmodule

// File: tb/tb_burst_arbiter.sv
// Directed self-checking bench for burst_arbiter (3 requesters).
module tb_burst_arbiter;

   localparam int N = 3;

   logic clk = 1'b0;
   logic rst_n;

   logic [N-1:0]    awv, awready, urg, wv, wready, wl;
   logic [N*4-1:0]  awid;
   logic [N*32-1:0] awaddr;
   logic [N*8-1:0]  awlen;
   logic [N*3-1:0]  awsize;
   logic [N*2-1:0]  awburst, awuser;
   logic [N*32-1:0] wdata;
   logic [N*4-1:0]  wstrb;

   logic        m_awvalid, m_awready;
   logic [3:0]  m_awid;
   logic [31:0] m_awaddr;
   logic [7:0]  m_awlen;
   logic [2:0]  m_awsize;
   logic [1:0]  m_awburst, m_awuser;
   logic        m_wvalid, m_wready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_wlast;
   logic [N-1:0] grant;
   logic        busy;
`ifdef BURST_ARB_LEN_CHECK_EN
   logic        len_err;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   burst_arbiter #(
      .NUM_REQ (N),
      .ID_W    (4),
      .ADDR_W  (32),
      .DATA_W  (32),
      .LEN_W   (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .r_awvalid (awv),
      .r_awready (awready),
      .r_awid    (awid),
      .r_awaddr  (awaddr),
      .r_awlen   (awlen),
      .r_awsize  (awsize),
      .r_awburst (awburst),
      .r_awuser  (awuser),
      .r_urgent  (urg),
      .r_wvalid  (wv),
      .r_wready  (wready),
      .r_wdata   (wdata),
      .r_wstrb   (wstrb),
      .r_wlast   (wl),
      .m_awvalid (m_awvalid),
      .m_awready (m_awready),
      .m_awid    (m_awid),
      .m_awaddr  (m_awaddr),
      .m_awlen   (m_awlen),
      .m_awsize  (m_awsize),
      .m_awburst (m_awburst),
      .m_awuser  (m_awuser),
      .m_wvalid  (m_wvalid),
      .m_wready  (m_wready),
      .m_wdata   (m_wdata),
      .m_wstrb   (m_wstrb),
      .m_wlast   (m_wlast),
      .grant     (grant),
      .busy      (busy)
`ifdef BURST_ARB_LEN_CHECK_EN
      ,
      .len_err   (len_err)
`endif
   );

   function automatic logic [31:0] beat_data(input int src, input int b);
      return 32'hA000_0000 | 32'(src << 8) | 32'(b);
   endfunction

   // Serves one burst: waits for m_awvalid, handshakes, then drives the
   // granted source's W beats. Only records observations; callers judge.
   // flags = {timeout, ready leaked to non-owner, wlast misplaced}
   task automatic serve(input int nbeats, input logic rearm, input logic toggle,
                        output int owner, output int good,
                        output logic [2:0] flags, output logic [31:0] addr_seen);
      int waitc, b, cyc;
      logic acc;
      logic [N-1:0] g;
      owner = -1; good = 0; flags = '0; addr_seen = '0; waitc = 0;
      @(negedge clk);
      while (!m_awvalid && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (!m_awvalid) begin
         flags[2] = 1'b1;
         return;
      end
      g = grant;
      for (int i = 0; i < N; i++) if (g == N'(1 << i)) owner = i;
      if (owner < 0) begin
         flags[1] = 1'b1;
         return;
      end
      addr_seen = m_awaddr;
      m_awready = 1'b1;
      #1;
      if (awready !== g) flags[1] = 1'b1;
      @(posedge clk); #1;
      m_awready  = 1'b0;
      awv[owner] = rearm;
      b = 0; cyc = 0;
      while (b < nbeats && cyc < 200) begin
         wv[owner] = 1'b1;
         wdata[owner*32 +: 32] = beat_data(owner, b);
         wl[owner] = (b == nbeats - 1);
         m_wready  = toggle ? cyc[0] : 1'b1;
         @(negedge clk);
         acc = m_wvalid && m_wready;
         if (((wready | awready) & ~g) != '0) flags[1] = 1'b1;
         if (acc) begin
            if (m_wdata === beat_data(owner, b) && m_wstrb === (4'hF ^ 4'(owner))) good++;
            if (m_wlast !== (b == nbeats - 1)) flags[0] = 1'b1;
         end
         @(posedge clk); #1;
         if (acc) b++;
         cyc++;
      end
      if (b < nbeats) flags[2] = 1'b1;
      wv[owner] = 1'b0;
      wl[owner] = 1'b0;
      m_wready  = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      awv = '0; urg = '0; wv = '0; wl = '0; m_awready = 1'b0; m_wready = 1'b1;
      for (int i = 0; i < N; i++) begin
         awid[i*4 +: 4]     = 4'(i + 5);
         awaddr[i*32 +: 32] = 32'h1000 * (i + 1);
         awlen[i*8 +: 8]    = 8'd3;
         awsize[i*3 +: 3]   = 3'd2;
         awburst[i*2 +: 2]  = 2'b01;
         awuser[i*2 +: 2]   = 2'(i);
         wdata[i*32 +: 32]  = 32'hDEAD_0000 | 32'(i);
         wstrb[i*4 +: 4]    = 4'hF ^ 4'(i);
      end
      wv[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({grant, busy, m_awvalid, m_wvalid, awready, wready} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl got grant=%b busy=%b awv=%b wv=%b awr=%b wr=%b want all 0",
                  grant, busy, m_awvalid, m_wvalid, awready, wready);
      end
      checks++;
      if ({m_awaddr, m_awid, m_awlen, m_wdata, m_wstrb, m_wlast} !== '0) begin
         errors++;
         $display("FAIL reset_payload got addr=%h wdata=%h want 0", m_awaddr, m_wdata);
      end
`ifdef BURST_ARB_LEN_CHECK_EN
      checks++;
      if (len_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_len_err got %b want 0", len_err);
      end
`endif
      repeat (2) @(negedge clk);
      checks++;
      if (wready !== '0 || m_wvalid !== 1'b0) begin
         errors++;
         $display("FAIL w_before_aw got wready=%b m_wvalid=%b want 0/0", wready, m_wvalid);
      end
      @(posedge clk); #1;
      wv = '0;
   endtask

   task automatic test_single;
      int owner, good;
      logic [2:0] fl;
      logic [31:0] a;
      awlen[0 +: 8] = 8'd3;
      awv[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (m_awvalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_latency got m_awvalid=%b busy=%b want 0/0", m_awvalid, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (m_awvalid !== 1'b1 || grant !== 3'b001 || busy !== 1'b1 || awready !== 3'b000) begin
         errors++;
         $display("FAIL single_addr got awv=%b grant=%b busy=%b awr=%b want 1/001/1/000",
                  m_awvalid, grant, busy, awready);
      end
      checks++;
      if (m_awid !== 4'd5 || m_awlen !== 8'd3 || m_awsize !== 3'd2 || m_awuser !== 2'd0) begin
         errors++;
         $display("FAIL single_aw_fields got id=%h len=%0d size=%0d user=%0d want 5/3/2/0",
                  m_awid, m_awlen, m_awsize, m_awuser);
      end
      serve(4, 1'b0, 1'b0, owner, good, fl, a);
      checks++;
      if (owner !== 0 || good !== 4 || fl !== 3'b000 || a !== 32'h1000) begin
         errors++;
         $display("FAIL single_burst got owner=%0d beats=%0d flags=%b addr=%h want 0/4/000/1000",
                  owner, good, fl, a);
      end
      checks++;
      if (grant !== 3'b000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_end got grant=%b busy=%b want 000/0", grant, busy);
      end
`ifdef BURST_ARB_LEN_CHECK_EN
      checks++;
      if (len_err !== 1'b0) begin
         errors++;
         $display("FAIL single_len_err got %b want 0", len_err);
      end
`endif
   endtask

   task automatic test_round_robin;
      int owner, good;
      logic [2:0] fl;
      logic [31:0] a;
      int exp_o[4] = '{1, 0, 1, 0};
      awlen[0 +: 8] = 8'd1;
      awlen[8 +: 8] = 8'd1;
      awv[0] = 1'b1;
      awv[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         serve(2, (k < 3), 1'b0, owner, good, fl, a);
         checks++;
         if (owner !== exp_o[k] || good !== 2 || fl !== 3'b000) begin
            errors++;
            $display("FAIL rr_burst%0d got owner=%0d beats=%0d flags=%b want %0d/2/000",
                     k, owner, good, fl, exp_o[k]);
         end
      end
      awv = '0;
   endtask

   task automatic test_urgent;
      int owner, good;
      logic [2:0] fl;
      logic [31:0] a;
      int exp_o[3] = '{2, 0, 1};
      for (int i = 0; i < N; i++) awlen[i*8 +: 8] = 8'd3;
      awv[0] = 1'b1;
      @(posedge clk); #1;
      awv[1] = 1'b1;
      awv[2] = 1'b1;
      urg[2] = 1'b1;
      serve(4, 1'b1, 1'b1, owner, good, fl, a);
      checks++;
      if (owner !== 0 || good !== 4 || fl !== 3'b000) begin
         errors++;
         $display("FAIL urg_no_preempt got owner=%0d beats=%0d flags=%b want 0/4/000",
                  owner, good, fl);
      end
      for (int k = 0; k < 3; k++) begin
         serve(4, 1'b0, 1'b0, owner, good, fl, a);
         urg = '0;
         checks++;
         if (owner !== exp_o[k] || good !== 4 || fl !== 3'b000) begin
            errors++;
            $display("FAIL urg_order%0d got owner=%0d beats=%0d flags=%b want %0d/4/000",
                     k, owner, good, fl, exp_o[k]);
         end
      end
      awv = '0;
   endtask

   task automatic test_both_urgent;
      int owner, good;
      logic [2:0] fl;
      logic [31:0] a;
      awv = 3'b111;
      urg = 3'b101;
      serve(1, 1'b0, 1'b0, owner, good, fl, a);
      checks++;
      if (owner !== 2 || good !== 1 || fl !== 3'b000 || a !== 32'h3000) begin
         errors++;
         $display("FAIL both_urg_ptr2 got owner=%0d beats=%0d flags=%b addr=%h want 2/1/000/3000",
                  owner, good, fl, a);
      end
      urg = 3'b010;
      serve(1, 1'b0, 1'b0, owner, good, fl, a);
      checks++;
      if (owner !== 1 || fl !== 3'b000) begin
         errors++;
         $display("FAIL urg_over_rr got owner=%0d flags=%b want 1/000", owner, fl);
      end
      urg = '0;
      serve(1, 1'b0, 1'b0, owner, good, fl, a);
      checks++;
      if (owner !== 0 || fl !== 3'b000) begin
         errors++;
         $display("FAIL rr_wrap got owner=%0d flags=%b want 0/000", owner, fl);
      end
      awv = '0;
   endtask

`ifdef BURST_ARB_LEN_CHECK_EN
   task automatic test_len_check;
      int owner, good;
      logic [2:0] fl;
      logic [31:0] a;
      awlen[0 +: 8] = 8'd3;
      awv[0] = 1'b1;
      serve(2, 1'b0, 1'b0, owner, good, fl, a);
      checks++;
      if (owner !== 0 || good !== 2 || len_err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL len_err_pulse got owner=%0d beats=%0d len_err=%b busy=%b want 0/2/1/0",
                  owner, good, len_err, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (len_err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL len_err_width got len_err=%b busy=%b want 0/0", len_err, busy);
      end
   endtask
`endif

   task automatic test_reset_mid_burst;
      int owner, good;
      logic [2:0] fl;
      logic [31:0] a;
      awlen[0 +: 8] = 8'd3;
      awv[0] = 1'b1;
      @(posedge clk); #1;
      m_awready = 1'b1;
      @(posedge clk); #1;
      m_awready = 1'b0;
      awv[0] = 1'b0;
      wv[0] = 1'b1;
      wdata[0 +: 32] = beat_data(0, 0);
      m_wready = 1'b1;
      @(posedge clk); #1;
      wdata[0 +: 32] = beat_data(0, 1);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || m_wvalid !== 1'b1 || m_wdata !== beat_data(0, 1)) begin
         errors++;
         $display("FAIL rst_pre got busy=%b m_wvalid=%b wdata=%h want 1/1/%h",
                  busy, m_wvalid, m_wdata, beat_data(0, 1));
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({grant, busy, m_wvalid, wready, m_awvalid, awready} !== '0 || m_wdata !== '0) begin
         errors++;
         $display("FAIL rst_mid got grant=%b busy=%b m_wvalid=%b wready=%b wdata=%h want all 0",
                  grant, busy, m_wvalid, wready, m_wdata);
      end
      wv = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      awv[0] = 1'b1;
      awv[1] = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (grant !== 3'b001) begin
         errors++;
         $display("FAIL rst_ptr got grant=%b want 001", grant);
      end
      awv[1] = 1'b0;
      serve(4, 1'b0, 1'b0, owner, good, fl, a);
      checks++;
      if (owner !== 0 || good !== 4 || fl !== 3'b000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_fresh_burst got owner=%0d beats=%0d flags=%b busy=%b want 0/4/000/0",
                  owner, good, fl, busy);
      end
      awv = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_urgent();
      test_both_urgent();
`ifdef BURST_ARB_LEN_CHECK_EN
      test_len_check();
`endif
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

endmodule
